// File: rtl/checker_pkg.sv
// checker_pkg
//   Definitions shared by cpu_checker and checker_log_collector:
//   record format codes, error bit positions and record field widths.
package checker_pkg;

  // Per-cycle record format reported by cpu_checker.
  // FMT_INV is never logged.
  typedef enum logic [1:0] {
    FMT_NONE = 2'b00,
    FMT_REG  = 2'b01,
    FMT_MEM  = 2'b10,
    FMT_INV  = 2'b11
  } fmt_e;

  // Bit positions inside error_code.
  localparam int ERR_TIME = 0;
  localparam int ERR_PC   = 1;
  localparam int ERR_ADDR = 2;
  localparam int ERR_GRF  = 3;

  // Record field widths.
  // A logged entry is {seq, format_type, error_code}.
  localparam int FMT_W = 2;
  localparam int ERR_W = 4;

endpackage

// File: rtl/checker_log_collector_if.sv
// checker_log_collector_if
//   Bundles the record stream, the log read port and the status outputs of
//   checker_log_collector.
//   master : the side producing records and draining the log (checker/bench).
//   slave  : the collector itself.
//   Signals:
//     format_type, error_code  record stream from cpu_checker
//     clear                    soft clear of log, counters and overflow
//     rd_valid/rd_ready/rd_data  head-of-log handshake
//     level                    log occupancy
//     reg_cnt, mem_cnt, err_cnt, drop_cnt, overflow  statistics
interface checker_log_collector_if #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
);
  logic [1:0]               format_type;
  logic [3:0]               error_code;
  logic                     clear;
  logic                     rd_ready;
  logic                     rd_valid;
  logic [CNT_W+5:0]         rd_data;
  logic [$clog2(DEPTH):0]   level;
  logic [CNT_W-1:0]         reg_cnt;
  logic [CNT_W-1:0]         mem_cnt;
  logic [CNT_W-1:0]         err_cnt;
  logic [CNT_W-1:0]         drop_cnt;
  logic                     overflow;

  modport master (
    output format_type, error_code, clear, rd_ready,
    input  rd_valid, rd_data, level, reg_cnt, mem_cnt, err_cnt, drop_cnt, overflow
  );

  modport slave (
    input  format_type, error_code, clear, rd_ready,
    output rd_valid, rd_data, level, reg_cnt, mem_cnt, err_cnt, drop_cnt, overflow
  );
endinterface

// File: rtl/log_fifo.sv
// log_fifo
//   Synchronous FIFO with a registered head output.
//   An entry pushed into an empty FIFO is visible on dout after that edge.
//   Ports:
//     clk, reset (sync, active-low)
//     flush  synchronous empty
//     push   write din (ignored when full unless a pop happens in the same cycle)
//     pop    consume the head (ignored when empty)
//     full, empty   derived from pointers that carry one extra wrap bit
//     level, valid, dout   registered occupancy / head-present / head data
module log_fifo #(
  parameter int WIDTH = 22,
  parameter int DEPTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               push,
  input  logic [WIDTH-1:0]   din,
  input  logic               pop,
  output logic               full,
  output logic               empty,
  output logic [$clog2(DEPTH):0] level,
  output logic               valid,
  output logic [WIDTH-1:0]   dout
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]      wr_ptr_next, rd_ptr_next;
  logic [AW:0]      level_reg;
  logic             valid_reg;
  logic [WIDTH-1:0] dout_reg;
  logic             do_push, do_pop;

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

  assign do_pop  = pop && !empty;
  // A pop frees the slot this cycle, so a full FIFO can still take a push.
  assign do_push = push && (!full || do_pop);

  assign wr_ptr_next = wr_ptr_reg + (AW+1)'(do_push);
  assign rd_ptr_next = rd_ptr_reg + (AW+1)'(do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      valid_reg  <= 1'b0;
      dout_reg   <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      level_reg  <= wr_ptr_next - rd_ptr_next;
      valid_reg  <= (wr_ptr_next != rd_ptr_next);
      // Registered read of the next head. The written slot can only be the
      // next head when the entry being pushed becomes the sole entry, so
      // forward din in that case instead of the stale memory word.
      if (do_push && (wr_ptr_reg[AW-1:0] == rd_ptr_next[AW-1:0])) begin
        dout_reg <= din;
      end else begin
        dout_reg <= mem[rd_ptr_next[AW-1:0]];
      end
    end
  end

  assign level = level_reg;
  assign valid = valid_reg;
  assign dout  = dout_reg;
endmodule

// File: rtl/checker_log_collector.sv
// checker_log_collector
//   Turns each completed cpu_checker record (format 01 or 10) into a
//   sequence-numbered entry in a small log FIFO and keeps saturating
//   statistics counters.
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous, active-low; clears everything including seq
//     bus    checker_log_collector_if.slave: record stream, clear, read
//            handshake (rd_valid/rd_ready/rd_data), level and statistics
module checker_log_collector
  import checker_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic reset,
  checker_log_collector_if.slave bus
);
  localparam int REC_W = CNT_W + FMT_W + ERR_W;

  logic             is_event;
  logic             push;
  logic             pop;
  logic             drop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] seq_reg;
  logic [CNT_W-1:0] reg_cnt_reg, mem_cnt_reg, err_cnt_reg, drop_cnt_reg;
  logic             overflow_reg;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Format 11 is treated exactly like 00.
  assign is_event = (bus.format_type == FMT_REG) || (bus.format_type == FMT_MEM);
  assign pop      = !fifo_empty && bus.rd_ready;
  // A clear discards a coinciding event entirely.
  assign push     = is_event && !bus.clear;
  assign drop     = push && fifo_full && !pop;

  log_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_log_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (bus.clear),
    .push  (push),
    .din   ({seq_reg, bus.format_type, bus.error_code}),
    .pop   (pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (bus.level),
    .valid (bus.rd_valid),
    .dout  (bus.rd_data)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      seq_reg      <= '0;
      reg_cnt_reg  <= '0;
      mem_cnt_reg  <= '0;
      err_cnt_reg  <= '0;
      drop_cnt_reg <= '0;
      overflow_reg <= 1'b0;
    end else if (bus.clear) begin
      // seq survives a soft clear so numbering stays unique across clears.
      reg_cnt_reg  <= '0;
      mem_cnt_reg  <= '0;
      err_cnt_reg  <= '0;
      drop_cnt_reg <= '0;
      overflow_reg <= 1'b0;
    end else if (is_event) begin
      seq_reg <= seq_reg + CNT_W'(1);
      if (bus.format_type == FMT_REG) begin
        reg_cnt_reg <= sat_inc(reg_cnt_reg);
      end else begin
        mem_cnt_reg <= sat_inc(mem_cnt_reg);
      end
      if (bus.error_code != '0) begin
        err_cnt_reg <= sat_inc(err_cnt_reg);
      end
      if (drop) begin
        drop_cnt_reg <= sat_inc(drop_cnt_reg);
        overflow_reg <= 1'b1;
      end
    end
  end

  assign bus.reg_cnt  = reg_cnt_reg;
  assign bus.mem_cnt  = mem_cnt_reg;
  assign bus.err_cnt  = err_cnt_reg;
  assign bus.drop_cnt = drop_cnt_reg;
  assign bus.overflow = overflow_reg;
endmodule

// File: tb/tb_checker_log_collector.sv
// tb_checker_log_collector
//   Drives two collectors (CNT_W=16 and CNT_W=4, both DEPTH=8) with the same
//   record stream and compares every output after every edge against a
//   queue-based model of the log.
module tb_checker_log_collector;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  checker_log_collector_if #(.DEPTH(DEPTH), .CNT_W(16)) bus  ();
  checker_log_collector_if #(.DEPTH(DEPTH), .CNT_W(4))  bus4 ();

  assign bus4.format_type = bus.format_type;
  assign bus4.error_code  = bus.error_code;
  assign bus4.clear       = bus.clear;
  assign bus4.rd_ready    = bus.rd_ready;

  checker_log_collector #(.DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  checker_log_collector #(.DEPTH(DEPTH), .CNT_W(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4)
  );

  // ---------------- reference model ----------------
  typedef struct {
    int         seq;
    logic [1:0] f;
    logic [3:0] e;
  } rec_t;

  rec_t q[$];
  int   m_seq = 0, m_reg = 0, m_mem = 0, m_err = 0, m_drop = 0;
  bit   m_ovf = 0;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic model_edge(input logic rst_n, input logic [1:0] f,
                            input logic [3:0] e, input logic clr, input logic rdy);
    bit ev;
    ev = (f == 2'b01) || (f == 2'b10);
    if (!rst_n || clr) begin
      q.delete();
      m_reg = 0; m_mem = 0; m_err = 0; m_drop = 0; m_ovf = 0;
      if (!rst_n) m_seq = 0;
    end else begin
      if (q.size() > 0 && rdy) void'(q.pop_front());
      if (ev) begin
        if (f == 2'b01) m_reg++; else m_mem++;
        if (e != 0) m_err++;
        if (q.size() < DEPTH) q.push_back('{m_seq, f, e});
        else begin
          m_drop++;
          m_ovf = 1;
        end
        m_seq++;
      end
    end
  endtask

  function automatic longint sat(input int c, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (c > mx) ? mx : longint'(c);
  endfunction

  function automatic longint rec_word(input rec_t r, input int w);
    longint s;
    s = longint'(r.seq) % (longint'(1) << w);
    return (s << 6) | (longint'(r.f) << 4) | longint'(r.e);
  endfunction

  task automatic check(input string tag, input longint obs, input longint exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    bit v;
    v = (q.size() > 0);
    check("valid16",    longint'(bus.rd_valid),  longint'(v));
    check("level16",    longint'(bus.level),     longint'(q.size()));
    check("reg16",      longint'(bus.reg_cnt),   sat(m_reg, 16));
    check("mem16",      longint'(bus.mem_cnt),   sat(m_mem, 16));
    check("err16",      longint'(bus.err_cnt),   sat(m_err, 16));
    check("drop16",     longint'(bus.drop_cnt),  sat(m_drop, 16));
    check("ovf16",      longint'(bus.overflow),  longint'(m_ovf));
    check("valid4",     longint'(bus4.rd_valid), longint'(v));
    check("level4",     longint'(bus4.level),    longint'(q.size()));
    check("reg4",       longint'(bus4.reg_cnt),  sat(m_reg, 4));
    check("mem4",       longint'(bus4.mem_cnt),  sat(m_mem, 4));
    check("err4",       longint'(bus4.err_cnt),  sat(m_err, 4));
    check("drop4",      longint'(bus4.drop_cnt), sat(m_drop, 4));
    check("ovf4",       longint'(bus4.overflow), longint'(m_ovf));
    if (v) begin
      check("data16", longint'(bus.rd_data),  rec_word(q[0], 16));
      check("data4",  longint'(bus4.rd_data), rec_word(q[0], 4));
    end
  endtask

  // One clock: apply inputs, advance the model at the edge, check 1 time unit later.
  task automatic step(input logic rst_n, input logic [1:0] f, input logic [3:0] e,
                      input logic clr, input logic rdy);
    reset           = rst_n;
    bus.format_type = f;
    bus.error_code  = e;
    bus.clear       = clr;
    bus.rd_ready    = rdy;
    @(posedge clk);
    model_edge(rst_n, f, e, clr, rdy);
    #1;
    check_all();
  endtask

  initial begin
    int saved_seq;
    int saved_lvl;
    logic [1:0] f;
    logic [3:0] e;

    reset = 1'b0;
    bus.format_type = 2'b00;
    bus.error_code  = 4'h0;
    bus.clear       = 1'b0;
    bus.rd_ready    = 1'b0;

    // Reset held two cycles while a register record is presented.
    step(1'b0, 2'b01, 4'h0, 1'b0, 1'b0);
    step(1'b0, 2'b01, 4'h0, 1'b0, 1'b0);
    check("rst_data16", longint'(bus.rd_data),  0);
    check("rst_data4",  longint'(bus4.rd_data), 0);
    step(1'b1, 2'b01, 4'h0, 1'b0, 1'b0);
    check("first_data", longint'(bus.rd_data), longint'({16'd0, 2'b01, 4'h0}));
    check("first_reg",  longint'(bus.reg_cnt), 1);

    // Mixed stream from a fresh reset, then drain in order.
    step(1'b0, 2'b00, 4'h0, 1'b0, 1'b0);
    step(1'b1, 2'b01, 4'h0, 1'b0, 1'b0);
    step(1'b1, 2'b10, 4'h4, 1'b0, 1'b0);
    step(1'b1, 2'b01, 4'h9, 1'b0, 1'b0);
    check("mix_level", longint'(bus.level),   3);
    check("mix_reg",   longint'(bus.reg_cnt), 2);
    check("mix_mem",   longint'(bus.mem_cnt), 1);
    check("mix_err",   longint'(bus.err_cnt), 2);
    for (int i = 0; i < 3; i++) begin
      check("mix_seq", longint'(bus.rd_data[21:6]), i);
      step(1'b1, 2'b00, 4'h0, 1'b0, 1'b1);
    end

    // Overflow: 10 events into an 8-deep log.
    step(1'b0, 2'b00, 4'h0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 2'b10, 4'h0, 1'b0, 1'b0);
    check("ovf_level", longint'(bus.level),    8);
    check("ovf_drop",  longint'(bus.drop_cnt), 2);
    check("ovf_flag",  longint'(bus.overflow), 1);
    for (int i = 0; i < 8; i++) begin
      check("ovf_seq", longint'(bus.rd_data[21:6]), i);
      step(1'b1, 2'b00, 4'h0, 1'b0, 1'b1);
    end
    step(1'b1, 2'b01, 4'h2, 1'b0, 1'b0);
    check("ovf_next_seq", longint'(bus.rd_data[21:6]), 10);

    // Refill to full, then push and pop in the same cycle.
    for (int i = 0; i < 7; i++) step(1'b1, 2'b01, 4'h0, 1'b0, 1'b0);
    step(1'b1, 2'b10, 4'h1, 1'b0, 1'b1);
    check("pp_level", longint'(bus.level),          8);
    check("pp_drop",  longint'(bus.drop_cnt),       2);
    check("pp_head",  longint'(bus.rd_data[21:6]),  11);

    // Invalid format changes nothing; clear discards a coinciding event.
    saved_lvl = q.size();
    step(1'b1, 2'b11, 4'hF, 1'b0, 1'b0);
    check("inv_level", longint'(bus.level), longint'(saved_lvl));
    saved_seq = m_seq;
    step(1'b1, 2'b10, 4'h3, 1'b1, 1'b0);
    check("clr_level", longint'(bus.level),   0);
    check("clr_mem",   longint'(bus.mem_cnt), 0);
    step(1'b1, 2'b10, 4'h0, 1'b0, 1'b0);
    check("clr_seq",   longint'(bus.rd_data[21:6]), longint'(saved_seq));

    // Single-entry push and pop: head is replaced, valid stays high.
    step(1'b1, 2'b01, 4'h8, 1'b0, 1'b1);
    check("one_pp_valid", longint'(bus.rd_valid), 1);

    // Saturation of the 4-bit instance and seq wrap.
    step(1'b0, 2'b00, 4'h0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 2'b01, 4'h0, 1'b0, 1'b1);
    step(1'b1, 2'b00, 4'h0, 1'b0, 1'b1);
    check("sat_reg4", longint'(bus4.reg_cnt), 15);
    step(1'b1, 2'b01, 4'h0, 1'b0, 1'b0);
    check("wrap_seq4",  longint'(bus4.rd_data[9:6]),  4);
    check("wrap_seq16", longint'(bus.rd_data[21:6]),  20);

    // Randomised traffic with occasional clear and reset.
    for (int i = 0; i < 600; i++) begin
      int r;
      int rdy_pct;
      r = int'($urandom_range(0, 9));
      f = (r < 4) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      e = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      rdy_pct = ((i / 50) % 2 == 0) ? 20 : 80;
      step(($urandom_range(0, 79) != 0), f, e, ($urandom_range(0, 49) == 0),
           (int'($urandom_range(0, 99)) < rdy_pct));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
